// File: rtl/conv_pkg.sv
// Shared constants for the rate-1/2 convolutional encoder and the Viterbi decoder.
// Generator polynomials are octal, indexed by constraint length K.
package conv_pkg;

  localparam int K_MIN = 3;
  localparam int K_MAX = 6;

  // Generator bit (K-1-j) taps the input delayed by j bits.
  localparam logic [5:0] G0 [K_MIN:K_MAX] = '{6'o07, 6'o15, 6'o23, 6'o53};
  localparam logic [5:0] G1 [K_MIN:K_MAX] = '{6'o05, 6'o17, 6'o35, 6'o75};

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    FLUSH
  } enc_state_t;

  function automatic logic parity(input logic [5:0] v);
    return ^v;
  endfunction

  function automatic logic [2:0] clamp_k(input logic [2:0] c);
    if (c < 3'(K_MIN)) return 3'(K_MIN);
    if (c > 3'(K_MAX)) return 3'(K_MAX);
    return c;
  endfunction

endpackage

// File: rtl/conv_parity_gen.sv
// Combinational tap-and-XOR of {shift register, current bit} against the
// g0/g1 generators selected by the constraint length k.
module conv_parity_gen
  import conv_pkg::*;
#(
  parameter int MAX_K = 6
) (
  input  logic             u,
  input  logic [MAX_K-2:0] sr,
  input  logic [2:0]       k,
  output logic [1:0]       sym
);

  logic [5:0]       g0, g1;
  logic [MAX_K-1:0] win, taps0, taps1;
  logic [2:0]       idx;

  always_comb begin
    case (k)
      3'd3:    begin g0 = G0[3]; g1 = G1[3]; end
      3'd4:    begin g0 = G0[4]; g1 = G1[4]; end
      3'd5:    begin g0 = G0[5]; g1 = G1[5]; end
      default: begin g0 = G0[6]; g1 = G1[6]; end
    endcase
    win   = {sr, u};
    taps0 = '0;
    taps1 = '0;
    idx   = '0;
    // Reverse the generator so window bit j lines up with generator bit K-1-j.
    for (int unsigned j = 0; j < MAX_K; j++) begin
      if (j < 32'(k)) begin
        idx      = k - 3'(j) - 3'd1;
        taps0[j] = g0[idx];
        taps1[j] = g1[idx];
      end
    end
    sym = {parity(6'(win & taps0)), parity(6'(win & taps1))};
  end

endmodule

// File: rtl/conv_encoder_sys.sv
// Framed rate-1/2 convolutional encoder with K-1 zero tail and run-time K (3..6).
// Optional rate-2/3 puncturing ([11;10]) when CONV_PUNCTURE_EN is defined.
module conv_encoder_sys
  import conv_pkg::*;
#(
  parameter int MAX_K   = 6,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] choose_constraint_length,
  input  logic       data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [1:0] encoded_bits,
  output logic       enc_valid,
  output logic       enc_last,
  input  logic       enc_ready
`ifdef CONV_PUNCTURE_EN
  ,
  output logic [1:0] sym_mask
`endif
);

  enc_state_t       state;
  logic [MAX_K-2:0] sr, sr_mask, sr_next;
  logic [2:0]       k_q, k_sel, tail_cnt;
  logic             load, step, u, last_sym;
  logic [1:0]       sym;

  assign load       = !enc_valid || enc_ready;
  assign data_ready = (state != FLUSH) && load && rst_n;
  assign k_sel      = (state == IDLE) ? clamp_k(choose_constraint_length) : k_q;
  assign u          = (state == FLUSH) ? 1'b0 : data_in;
  assign step       = (state == FLUSH) ? load : (data_valid && data_ready);

  always_comb begin
    sr_mask = '0;
    for (int unsigned j = 0; j < 32'(MAX_K - 1); j++) begin
      sr_mask[j] = (j + 1 < 32'(k_sel));
    end
    sr_next  = {sr[MAX_K-3:0], u} & sr_mask;
    last_sym = (state == FLUSH) ? (tail_cnt == 3'd1) : (data_last && !TAIL_EN);
  end

`ifdef CONV_PUNCTURE_EN
  logic odd_q, odd_cur;
  // Every frame's first symbol is an even (full) symbol.
  assign odd_cur = (state == IDLE) ? 1'b0 : odd_q;
`endif

  conv_parity_gen #(.MAX_K(MAX_K)) u_parity (
    .u   (u),
    .sr  (sr),
    .k   (k_sel),
    .sym (sym)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      k_q          <= 3'(K_MIN);
      tail_cnt     <= '0;
      enc_valid    <= 1'b0;
      enc_last     <= 1'b0;
      encoded_bits <= '0;
`ifdef CONV_PUNCTURE_EN
      sym_mask     <= '1;
      odd_q        <= 1'b0;
`endif
    end else if (step) begin
      sr        <= sr_next;
      enc_valid <= 1'b1;
      enc_last  <= last_sym;
`ifdef CONV_PUNCTURE_EN
      encoded_bits <= {sym[1], sym[0] & !odd_cur};
      sym_mask     <= odd_cur ? 2'b10 : 2'b11;
      odd_q        <= !odd_cur;
`else
      encoded_bits <= sym;
`endif
      case (state)
        IDLE, ENCODE: begin
          if (state == IDLE) k_q <= k_sel;
          if (data_last) begin
            if (TAIL_EN) begin
              state    <= FLUSH;
              tail_cnt <= k_sel - 3'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= ENCODE;
          end
        end
        FLUSH: begin
          tail_cnt <= tail_cnt - 3'd1;
          if (tail_cnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (load) begin
      enc_valid <= 1'b0;
      enc_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_sys.sv
// Directed scoreboard bench for conv_encoder_sys: reference convolution model,
// backpressure, K clamping, mid-flush reset and optional puncturing.
module tb_conv_encoder_sys;
  import conv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] choose;
  logic       data_in, data_valid, data_last;
  logic       data_ready;
  logic [1:0] encoded_bits;
  logic       enc_valid, enc_last;
  logic       enc_ready = 1'b1;
`ifdef CONV_PUNCTURE_EN
  logic [1:0] sym_mask;
`endif

  typedef struct packed {
    logic [1:0] bits;
    logic       last;
    logic [1:0] mask;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         k_m = 3;
  int         sidx = 0;
  logic [7:0] hist = '0;
  bit         stall_mode = 1'b0;
  logic [1:0] rdy_idx = '0;
  logic [3:0] rdy_pat = 4'b1001;

  always #5 clk = ~clk;

  conv_encoder_sys dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .choose_constraint_length (choose),
    .data_in                  (data_in),
    .data_valid               (data_valid),
    .data_last                (data_last),
    .data_ready               (data_ready),
    .encoded_bits             (encoded_bits),
    .enc_valid                (enc_valid),
    .enc_last                 (enc_last),
    .enc_ready                (enc_ready)
`ifdef CONV_PUNCTURE_EN
    ,
    .sym_mask                 (sym_mask)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [1:0] ref_sym(input int k, input logic [7:0] h, input logic u);
    logic [5:0] g0, g1;
    logic [8:0] win;
    logic       p0, p1, w;
    case (k)
      3:       begin g0 = 6'o07; g1 = 6'o05; end
      4:       begin g0 = 6'o15; g1 = 6'o17; end
      5:       begin g0 = 6'o23; g1 = 6'o35; end
      default: begin g0 = 6'o53; g1 = 6'o75; end
    endcase
    win = {h, u};
    p0  = 1'b0;
    p1  = 1'b0;
    for (int j = 0; j < k; j++) begin
      w = ((win >> j) & 9'd1) != 9'd0;
      if (((g0 >> (k - 1 - j)) & 6'd1) != 6'd0) p0 ^= w;
      if (((g1 >> (k - 1 - j)) & 6'd1) != 6'd0) p1 ^= w;
    end
    return {p0, p1};
  endfunction

  task automatic push(input logic u, input logic last);
    exp_t       e;
    logic [8:0] win;
    e.bits = ref_sym(k_m, hist, u);
    e.last = last;
    e.mask = 2'b11;
    win    = {hist, u};
    hist   = win[7:0] & ((8'd1 << (k_m - 1)) - 8'd1);
`ifdef CONV_PUNCTURE_EN
    if (sidx % 2 == 1) begin
      e.bits[0] = 1'b0;
      e.mask    = 2'b10;
    end
`endif
    sidx++;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (stall_mode) begin
      enc_ready = rdy_pat[rdy_idx];
      rdy_idx++;
    end else begin
      enc_ready = 1'b1;
      rdy_idx   = '0;
    end
  end

  // Scoreboard: a valid symbol must match the queue head every cycle it is shown.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && enc_valid === 1'b1) begin
      chk("sym_expected", 8'(q.size() != 0), 8'd1);
      if (q.size() != 0) begin
        e = q[0];
        chk("encoded_bits", 8'(encoded_bits), 8'(e.bits));
        chk("enc_last", 8'(enc_last), 8'(e.last));
`ifdef CONV_PUNCTURE_EN
        chk("sym_mask", 8'(sym_mask), 8'(e.mask));
`endif
        if (enc_ready) void'(q.pop_front());
      end
    end
  end

  task automatic wait_drain();
    for (int c = 0; c < 400 && (q.size() != 0 || enc_valid === 1'b1); c++) begin
      @(posedge clk);
      #2;
    end
    chk("drain_queue_empty", 8'(q.size() == 0), 8'd1);
    chk("drain_valid_low", 8'(enc_valid), 8'd0);
  endtask

  task automatic run_frame(input int cfg0, input int cfg1, input logic [15:0] bits,
                           input int n, input bit abort, input bit chk_flush);
    bit ok;
    k_m    = (cfg0 < 3) ? 3 : (cfg0 > 6) ? 6 : cfg0;
    sidx   = 0;
    choose = 3'(cfg0);
    for (int i = 0; i < n; i++) begin
      data_in    = bits[i];
      data_last  = (i == n - 1);
      data_valid = 1'b1;
      ok         = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        ok = data_ready;
        @(posedge clk);
        #1;
      end
      chk("bit_accepted", 8'(ok), 8'd1);
      if (ok) push(bits[i], 1'b0);
      if (i == 0) choose = 3'(cfg1);
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    data_in    = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_valid_low", 8'(enc_valid), 8'd0);
      chk("abort_last_low", 8'(enc_last), 8'd0);
      chk("abort_ready_low", 8'(data_ready), 8'd0);
      rst_n = 1'b1;
      q.delete();
      hist = '0;
      return;
    end
    for (int t = 0; t < k_m - 1; t++) push(1'b0, t == k_m - 2);
    if (chk_flush) begin
      chk("flush_ready_0", 8'(data_ready), 8'd0);
      @(posedge clk);
      #1;
      chk("flush_ready_1", 8'(data_ready), 8'd0);
      @(posedge clk);
      #1;
      chk("post_flush_ready", 8'(data_ready), 8'd1);
    end
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n      = 1'b0;
    choose     = 3'd3;
    data_in    = 1'b0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_valid", 8'(enc_valid), 8'd0);
    chk("rst_enc_last", 8'(enc_last), 8'd0);
    chk("rst_encoded_bits", 8'(encoded_bits), 8'd0);
    chk("rst_data_ready", 8'(data_ready), 8'd0);
`ifdef CONV_PUNCTURE_EN
    chk("rst_sym_mask", 8'(sym_mask), 8'd3);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_data_ready", 8'(data_ready), 8'd1);

    // K=3, bits 1,0,1,1 with tail
    run_frame(3, 3, 16'b1101, 4, 1'b0, 1'b1);

    // K=4 impulse response
    run_frame(4, 4, 16'b1, 1, 1'b0, 1'b0);
    chk("k4_sr_zero", 8'(dut.sr), 8'd0);
    chk("k4_state_idle", 8'(dut.state == IDLE), 8'd1);

    // Same K=3 frame under backpressure 1,0,0,1,...
    stall_mode = 1'b1;
    run_frame(3, 3, 16'b1101, 4, 1'b0, 1'b0);
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    // K request 7 clamps to 6; mid-frame change to 3 is ignored
    run_frame(7, 3, 16'b11001011, 8, 1'b0, 1'b0);

    // Reset on first tail cycle, then the K=3 frame again from state 0
    run_frame(3, 3, 16'b1101, 4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    run_frame(3, 3, 16'b1101, 4, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder_sys.md
Name: conv_encoder_sys

Overview:
- Rate-1/2 feed-forward convolutional encoder; the transmit-side counterpart of the team's Viterbi decoder.
- Accepts a framed serial bit stream and emits one 2-bit symbol per input bit.
- Appends K-1 zero tail symbols after the last bit so the decoder trellis terminates in state 0.
- Constraint length is run-time selectable, 3 to 6, and is latched per frame.

Parameters:
- MAX_K, 6, largest supported constraint length; sets the shift-register width (MAX_K-1).
- TAIL_EN, 1, 1 = append the K-1 zero-input tail after data_last; 0 = end frame with no tail and keep state across frames.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- choose_constraint_length  in  3  K for the next frame (3-6)
- data_in  in  1  information bit
- data_valid  in  1  data_in valid
- data_last  in  1  marks the last bit of the frame
- data_ready  out  1  encoder accepts a bit this cycle
- encoded_bits  out  2  [1] = g0 parity, [0] = g1 parity
- enc_valid  out  1  encoded_bits valid
- enc_last  out  1  last symbol of the frame
- enc_ready  in  1  downstream accepts a symbol
- sym_mask  out  2  present only with CONV_PUNCTURE_EN; per-bit validity of encoded_bits

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, shift register=0, enc_valid=0, enc_last=0, encoded_bits=2'b00, data_ready=0 during reset, sym_mask=2'b11, tail/puncture counters=0. Reset mid-frame or mid-flush abandons the frame and emits no partial tail.
- Window convention:
  - w[0] = current input; w[j] = input j bits earlier.
  - Trellis state = {w[K-1]..w[1]}, so state[0] = most recent past bit.
  - Generator bit (K-1-j) taps w[j].
  - Output bit = XOR of tapped bits.
- Generators (octal, g0/g1):
  - K=3: 7/5
  - K=4: 15/17
  - K=5: 23/35
  - K=6: 53/75
- For K=3 this yields, from states 0..3 with input 0/1: 00/11, 10/01, 11/00, 01/10.
- Output register: a single-entry pipeline register, loaded when (!enc_valid || enc_ready). Latency is 1 cycle from input handshake to enc_valid. No combinational path from data_valid to enc_valid.
- data_ready = (state != FLUSH) && (!enc_valid || enc_ready) && rst_n.
- FSM:
  - IDLE: on the first accepted bit, latch K = clamp(choose_constraint_length, 3, 6), encode the bit, go to ENCODE. If data_last is also set, go to FLUSH (TAIL_EN=1) or stay IDLE.
  - ENCODE: encode each accepted bit. On an accepted bit with data_last=1, go to FLUSH (TAIL_EN=1), else go to IDLE with enc_last set on that symbol.
  - FLUSH: data_ready=0. Inject K-1 zero bits, one per output-register load. enc_last=1 on the final tail symbol. Afterwards the shift register is 0; go to IDLE.
- Backpressure (enc_valid && !enc_ready): hold encoded_bits, enc_last and sym_mask stable; no shift and no tail advance.
- choose_constraint_length changes mid-frame are ignored until the next IDLE.
- Values 0-2 encode as K=3; value 7 encodes as K=6.
- Only the low K-1 shift-register bits participate. Higher bits stay 0.

Optional Feature:
- Macro: CONV_PUNCTURE_EN.
- Defined: rate-2/3 puncturing with pattern [11;10].
  - Symbol counter toggles per emitted symbol (data and tail), and resets to 0 at frame start.
  - Even symbols: sym_mask=2'b11.
  - Odd symbols: sym_mask=2'b10 and encoded_bits[0] driven 0.
  - The sym_mask port exists.
- Undefined: no sym_mask port, no counter, every symbol is full rate.

Decomposition:
- Package conv_pkg holds:
  - the G0/G1 lookup arrays indexed by K (localparam logic [5:0]);
  - K_MIN=3 and K_MAX=6;
  - enc_state_t enum {IDLE, ENCODE, FLUSH};
  - a parity function.
- The decoder reuses the same generator constants from this package.
- One sub-module: conv_parity_gen, a combinational tap-and-XOR of {u, shift register} against g0/g1 for the latched K.

Test Plan:
- K=3, bits 1,0,1,1 (last on 4th), enc_ready=1 -> symbols 11,10,00,01 then tail 01,11; enc_last only on the 6th; data_ready=0 during the 2 tail cycles.
- K=4, single bit 1 with data_last -> 11,11,01,11 (impulse response); shift register 0 afterwards, FSM in IDLE.
- K=3 sequence from test 1 with enc_ready toggling 1,0,0,1,... -> identical symbol sequence, outputs stable while stalled, no dropped or duplicated symbols.
- choose_constraint_length=7 at frame start, changed to 3 mid-frame -> frame encoded with K=6 generators 53/75 and 5 tail symbols.
- Reset asserted on the first FLUSH cycle of test 1 -> next cycle enc_valid=0, enc_last=0; a new frame starting from state 0 reproduces test 1 exactly.
- With CONV_PUNCTURE_EN, test 1 stimulus -> sym_mask 11,10,11,10,11,10; encoded_bits 11,10,00,00,01,10.
